// File: rtl/axi_pkg.sv
// Shared AXI4 constants, encodings and write-engine state type.
package axi_pkg;

  localparam int ADDR_BITS = 32;
  localparam int DATA_BITS = 32;
  localparam int LEN_BITS  = 8;
  localparam int SIZE_BITS = 3;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_ADDR = 2'd1,
    WR_DATA = 2'd2,
    WR_RESP = 2'd3
  } wr_state_t;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp != RESP_OKAY);
  endfunction

endpackage

// File: rtl/axi_master_wr_if.sv
// AXI4 write channels (AW, W, B) between a write master and a write slave.
interface axi_master_wr_if #(
  parameter int ADDR_BITS = axi_pkg::ADDR_BITS,
  parameter int DATA_BITS = axi_pkg::DATA_BITS,
  parameter int LEN_BITS  = axi_pkg::LEN_BITS,
  parameter int SIZE_BITS = axi_pkg::SIZE_BITS
);

  logic                   aw_valid;
  logic                   aw_ready;
  logic [ADDR_BITS-1:0]   aw_addr;
  logic [LEN_BITS-1:0]    aw_len;
  logic [SIZE_BITS-1:0]   aw_size;
  logic [1:0]             aw_burst;
  logic [3:0]             aw_cache;

  logic                   w_valid;
  logic                   w_ready;
  logic [DATA_BITS-1:0]   w_data;
  logic [DATA_BITS/8-1:0] w_strb;
  logic                   w_last;

  logic                   b_valid;
  logic                   b_ready;
  logic [1:0]             b_resp;

  modport master (
    output aw_valid, aw_addr, aw_len, aw_size, aw_burst, aw_cache,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last,
    input  w_ready,
    input  b_valid, b_resp,
    output b_ready
  );

  modport slave (
    input  aw_valid, aw_addr, aw_len, aw_size, aw_burst, aw_cache,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last,
    output w_ready,
    output b_valid, b_resp,
    input  b_ready
  );

endinterface

// File: rtl/axi_resp_timer.sv
// Counts cycles spent waiting for the B response; expired once TIMEOUT_CYCLES have elapsed.
module axi_resp_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic expired
);

  localparam int CNT_BITS = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_BITS-1:0] LIMIT = CNT_BITS'(TIMEOUT_CYCLES);

  logic [CNT_BITS-1:0] cnt_r;

  // Cleared whenever the engine is outside RESP, saturates at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (!run) begin
      cnt_r <= '0;
    end else if (cnt_r != LIMIT) begin
      cnt_r <= cnt_r + CNT_BITS'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Expiry flag
  always_comb begin
    expired = (cnt_r == LIMIT);
  end

endmodule

// File: rtl/axi_master_wr.sv
// AXI4 write master: one outstanding burst (AW, len+1 W beats, B) per client command.
// Define AXI_MST_WR_TIMEOUT_EN to abort a missing B response after TIMEOUT_CYCLES.
module axi_master_wr #(
  parameter int ADDR_BITS    = axi_pkg::ADDR_BITS,
  parameter int DATA_BITS    = axi_pkg::DATA_BITS,
  parameter int LEN_BITS     = axi_pkg::LEN_BITS,
  parameter int SIZE_BITS    = axi_pkg::SIZE_BITS,
  parameter int ERR_CNT_BITS = 8
`ifdef AXI_MST_WR_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                    aclk,
  input  logic                    areset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_BITS-1:0]    cmd_addr,
  input  logic [LEN_BITS-1:0]     cmd_len,
  input  logic [SIZE_BITS-1:0]    cmd_size,
  input  logic                    wd_valid,
  output logic                    wd_ready,
  input  logic [DATA_BITS-1:0]    wd_data,
  input  logic [DATA_BITS/8-1:0]  wd_strb,
  output logic                    done,
  output logic [1:0]              done_resp,
  output logic [ERR_CNT_BITS-1:0] err_cnt,
`ifdef AXI_MST_WR_TIMEOUT_EN
  output logic                    timeout,
`endif
  axi_master_wr_if.master         axi
);

  import axi_pkg::*;

  localparam logic [1:0] ST_IDLE = 2'(WR_IDLE);
  localparam logic [1:0] ST_ADDR = 2'(WR_ADDR);
  localparam logic [1:0] ST_DATA = 2'(WR_DATA);
  localparam logic [1:0] ST_RESP = 2'(WR_RESP);

  logic [1:0]              state_r;
  logic [ADDR_BITS-1:0]    addr_r;
  logic [LEN_BITS-1:0]     len_r;
  logic [SIZE_BITS-1:0]    size_r;
  logic [LEN_BITS-1:0]     beat_cnt_r;
  logic [ERR_CNT_BITS-1:0] err_cnt_r;

  logic       in_idle_s;
  logic       in_addr_s;
  logic       in_data_s;
  logic       in_resp_s;
  logic       aw_hs_s;
  logic       w_hs_s;
  logic       last_beat_s;
  logic       b_hs_s;
  logic       timeout_s;
  logic       done_s;
  logic [1:0] done_resp_s;

  // State decode and handshake qualifiers
  always_comb begin
    in_idle_s   = (state_r == ST_IDLE);
    in_addr_s   = (state_r == ST_ADDR);
    in_data_s   = (state_r == ST_DATA);
    in_resp_s   = (state_r == ST_RESP);
    last_beat_s = (beat_cnt_r == len_r);
    aw_hs_s     = in_addr_s & axi.aw_ready;
    w_hs_s      = in_data_s & wd_valid & axi.w_ready;
    b_hs_s      = in_resp_s & axi.b_valid;
  end

`ifdef AXI_MST_WR_TIMEOUT_EN
  logic expired_s;

  axi_resp_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_resp_timer (
    .clk     (aclk),
    .rst_n   (areset_n),
    .run     (in_resp_s),
    .expired (expired_s)
  );

  // A real B handshake in the expiry cycle takes precedence over the timeout.
  always_comb begin
    timeout_s = in_resp_s & expired_s & ~axi.b_valid;
    timeout   = timeout_s;
  end
`else
  // No timeout: RESP waits for the slave indefinitely.
  always_comb begin
    timeout_s = 1'b0;
  end
`endif

  // Completion pulse and response selection
  always_comb begin
    done_s = b_hs_s | timeout_s;
    if (b_hs_s) begin
      done_resp_s = axi.b_resp;
    end else if (timeout_s) begin
      done_resp_s = RESP_SLVERR;
    end else begin
      done_resp_s = RESP_OKAY;
    end
    done      = done_s;
    done_resp = done_resp_s;
    err_cnt   = err_cnt_r;
    cmd_ready = in_idle_s;
  end

  // AW channel: fields come from the latched command and are zero outside ADDR.
  always_comb begin
    axi.aw_valid = in_addr_s;
    if (in_addr_s) begin
      axi.aw_addr  = addr_r;
      axi.aw_len   = len_r;
      axi.aw_size  = size_r;
      axi.aw_burst = BURST_INCR;
      axi.aw_cache = 4'b0000;
    end else begin
      axi.aw_addr  = '0;
      axi.aw_len   = '0;
      axi.aw_size  = '0;
      axi.aw_burst = 2'b00;
      axi.aw_cache = 4'b0000;
    end
  end

  // W channel: client stream passes straight through while in DATA.
  always_comb begin
    axi.w_valid = in_data_s & wd_valid;
    wd_ready    = in_data_s & axi.w_ready;
    axi.w_last  = in_data_s & wd_valid & last_beat_s;
    if (in_data_s) begin
      axi.w_data = wd_data;
      axi.w_strb = wd_strb;
    end else begin
      axi.w_data = '0;
      axi.w_strb = '0;
    end
    axi.b_ready = in_resp_s;
  end

  // Transaction FSM with command latch and beat counter
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_r    <= ST_IDLE;
      addr_r     <= '0;
      len_r      <= '0;
      size_r     <= '0;
      beat_cnt_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr_r     <= cmd_addr;
            len_r      <= cmd_len;
            size_r     <= cmd_size;
            beat_cnt_r <= '0;
            state_r    <= ST_ADDR;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_ADDR: begin
          if (aw_hs_s) begin
            state_r <= ST_DATA;
          end else begin
            state_r <= ST_ADDR;
          end
        end
        ST_DATA: begin
          // The counter stops at len so len=all-ones never wraps before w_last.
          if (w_hs_s && last_beat_s) begin
            state_r <= ST_RESP;
          end else if (w_hs_s) begin
            beat_cnt_r <= beat_cnt_r + LEN_BITS'(1);
          end else begin
            state_r <= ST_DATA;
          end
        end
        ST_RESP: begin
          if (done_s) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_RESP;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Saturating count of non-OKAY completions
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      err_cnt_r <= '0;
    end else if (done_s && resp_is_err(done_resp_s) && (err_cnt_r != {ERR_CNT_BITS{1'b1}})) begin
      err_cnt_r <= err_cnt_r + ERR_CNT_BITS'(1);
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

endmodule

// File: tb/tb_axi_master_wr.sv
// Randomized self-checking bench for axi_master_wr with a behavioural client/slave model.
module tb_axi_master_wr;

  logic        aclk;
  logic        areset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic        wd_valid;
  logic        wd_ready;
  logic [31:0] wd_data;
  logic [3:0]  wd_strb;
  logic        done;
  logic [1:0]  done_resp;
  logic [7:0]  err_cnt;
`ifdef AXI_MST_WR_TIMEOUT_EN
  logic        timeout;
`endif

  axi_master_wr_if #(.ADDR_BITS(32), .DATA_BITS(32), .LEN_BITS(8), .SIZE_BITS(3)) axi ();

  axi_master_wr #(
    .ADDR_BITS(32), .DATA_BITS(32), .LEN_BITS(8), .SIZE_BITS(3), .ERR_CNT_BITS(8)
`ifdef AXI_MST_WR_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .aclk(aclk), .areset_n(areset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .done(done), .done_resp(done_resp), .err_cnt(err_cnt),
`ifdef AXI_MST_WR_TIMEOUT_EN
    .timeout(timeout),
`endif
    .axi(axi)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  int err_exp = 0;

  logic [31:0] tx_data[$];
  logic [3:0]  tx_strb[$];
  logic [31:0] obs_data[$];
  logic [3:0]  obs_strb[$];
  logic [31:0] obs_aw_addr;
  logic [7:0]  obs_aw_len;
  logic [2:0]  obs_aw_size;
  logic [1:0]  obs_aw_burst;
  logic [3:0]  obs_aw_cache;
  logic [1:0]  obs_resp;
  bit aw_unstable, w_early, gap_leak, last_stray, b_early, hang;
  bit last_final, obs_timeout, ready_after, done_after;
  int obs_nlast, t_cmd, t_aw, t_lastw, t_done, done_n;

  task automatic fill_data(input int len);
    tx_data.delete();
    tx_strb.delete();
    for (int i = 0; i <= len; i++) begin
      tx_data.push_back($urandom);
      tx_strb.push_back(4'($urandom_range(0, 15)));
    end
  endtask

  task automatic idle_inputs();
    cmd_valid = 1'b0; cmd_addr = 32'h0; cmd_len = 8'h0; cmd_size = 3'h0;
    wd_valid = 1'b0; wd_data = 32'h0; wd_strb = 4'h0;
    axi.aw_ready = 1'b0; axi.w_ready = 1'b0; axi.b_valid = 1'b0; axi.b_resp = 2'b00;
  endtask

  // Plays client and slave for one transaction and records what the engine did.
  task automatic run_txn(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input int aw_wait, input int wr_mode, input int gap_after, input int gap_len,
                         input logic [1:0] bresp, input int b_wait, input bit b_never, input bit b_spur);
    bit cmd_done = 1'b0, aw_done = 1'b0, last_seen = 1'b0, in_gap;
    int aw_seen = 0, widx = 0, gap_cnt = 0, b_cnt = 0;
    obs_data.delete(); obs_strb.delete();
    aw_unstable = 0; w_early = 0; gap_leak = 0; last_stray = 0; b_early = 0; hang = 1;
    last_final = 0; obs_timeout = 0; obs_nlast = 0; done_n = 0;
    t_cmd = -1; t_aw = -1; t_lastw = -1; t_done = -1; obs_resp = 2'b00;
    for (int k = 0; k < 3000; k++) begin
      @(negedge aclk);
      cmd_valid = !cmd_done; cmd_addr = addr; cmd_len = len; cmd_size = size;
      in_gap = (gap_len > 0) && (widx == gap_after) && (gap_cnt < gap_len);
      wd_valid = cmd_done && (widx <= int'(len)) && !in_gap;
      wd_data = (widx <= int'(len)) ? tx_data[widx] : 32'h0;
      wd_strb = (widx <= int'(len)) ? tx_strb[widx] : 4'h0;
      if (in_gap) gap_cnt++;
      axi.aw_ready = (aw_seen >= aw_wait);
      case (wr_mode)
        0:       axi.w_ready = 1'b1;
        1:       axi.w_ready = (k % 2 == 0);
        default: axi.w_ready = 1'($urandom_range(0, 1));
      endcase
      axi.b_valid = (last_seen && !b_never && b_cnt >= b_wait) || (b_spur && !last_seen);
      axi.b_resp = bresp;
      #1;
      if (cmd_valid && cmd_ready) begin cmd_done = 1'b1; t_cmd = k; end
      if (axi.w_valid && !aw_done) w_early = 1;
      if (axi.b_ready && !last_seen) b_early = 1;
      if (axi.aw_valid && !aw_done) begin
        if (aw_seen == 0) begin
          obs_aw_addr = axi.aw_addr; obs_aw_len = axi.aw_len; obs_aw_size = axi.aw_size;
          obs_aw_burst = axi.aw_burst; obs_aw_cache = axi.aw_cache;
        end else if (axi.aw_addr != obs_aw_addr || axi.aw_len != obs_aw_len || axi.aw_size != obs_aw_size
                     || axi.aw_burst != obs_aw_burst || axi.aw_cache != obs_aw_cache) begin
          aw_unstable = 1;
        end
        aw_seen++;
        if (axi.aw_ready) begin aw_done = 1'b1; t_aw = k; end
      end
      if (in_gap && axi.w_valid) gap_leak = 1;
      if (axi.w_last && !axi.w_valid) last_stray = 1;
      if (axi.w_valid && axi.w_ready) begin
        obs_data.push_back(axi.w_data); obs_strb.push_back(axi.w_strb);
        last_final = axi.w_last;
        if (axi.w_last) begin obs_nlast++; t_lastw = k; last_seen = 1'b1; end
        widx++;
      end
      if (done) begin
        done_n++; obs_resp = done_resp; t_done = k; hang = 0;
`ifdef AXI_MST_WR_TIMEOUT_EN
        obs_timeout = timeout;
`endif
      end
      if (last_seen) b_cnt++;
      if (done) break;
    end
    @(negedge aclk);
    idle_inputs();
    #1;
    ready_after = cmd_ready;
    done_after = done;
    if (bresp != 2'b00 || b_never) err_exp = (err_exp < 255) ? err_exp + 1 : 255;
  endtask

  task automatic test_reset();
    idle_inputs();
    areset_n = 1'b0;
    repeat (3) @(negedge aclk);
    #1;
    checks++;
    if ({cmd_ready, axi.aw_valid, axi.w_valid, axi.w_last, axi.b_ready, done} !== 6'b100000) begin
      errors++; $display("FAIL reset_ctrl got %b exp 100000", {cmd_ready, axi.aw_valid, axi.w_valid, axi.w_last, axi.b_ready, done});
    end
    checks++;
    if ({done_resp, err_cnt, axi.aw_addr, axi.aw_len, axi.aw_burst, axi.aw_cache, axi.w_data} !== 86'h0) begin
      errors++; $display("FAIL reset_data got %h exp 0", {done_resp, err_cnt, axi.aw_addr, axi.aw_len, axi.aw_burst, axi.aw_cache, axi.w_data});
    end
    areset_n = 1'b1;
    @(negedge aclk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b exp 1", cmd_ready); end
  endtask

  task automatic test_single();
    fill_data(0);
    tx_data[0] = 32'hDEADBEEF;
    run_txn(32'h10, 8'd0, 3'd2, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    checks++;
    if ({obs_aw_addr, obs_aw_len, obs_aw_size, obs_aw_burst, obs_aw_cache} !== {32'h10, 8'd0, 3'd2, 2'b01, 4'b0000}) begin
      errors++; $display("FAIL single_aw got %h/%h/%h/%b/%h exp 10/0/2/01/0", obs_aw_addr, obs_aw_len, obs_aw_size, obs_aw_burst, obs_aw_cache);
    end
    checks++;
    if (obs_data.size() != 1 || obs_data[0] !== 32'hDEADBEEF || !last_final || obs_nlast != 1) begin
      errors++; $display("FAIL single_beat got n=%0d last=%0d exp n=1 data deadbeef last=1", obs_data.size(), obs_nlast);
    end
    checks++;
    if ({t_aw - t_cmd, t_lastw - t_cmd, t_done - t_cmd} !== {32'd1, 32'd2, 32'd3}) begin
      errors++; $display("FAIL single_latency got aw=%0d w=%0d done=%0d exp 1/2/3", t_aw - t_cmd, t_lastw - t_cmd, t_done - t_cmd);
    end
    checks++;
    if (obs_resp !== 2'b00 || ready_after !== 1'b1 || done_after !== 1'b0 || hang) begin
      errors++; $display("FAIL single_done got resp=%b ready=%b done_after=%b hang=%0d exp 00/1/0/0", obs_resp, ready_after, done_after, hang);
    end
  endtask

  task automatic test_burst4();
    int bad = 0;
    fill_data(3);
    run_txn(32'h1000, 8'd3, 3'd2, 3, 1, 0, 0, 2'b00, 1, 0, 0);
    checks++;
    if (aw_unstable || w_early || t_aw - t_cmd != 4) begin
      errors++; $display("FAIL burst4_aw got unstable=%0d early=%0d aw_at=%0d exp 0/0/4", aw_unstable, w_early, t_aw - t_cmd);
    end
    for (int i = 0; i < obs_data.size() && i < tx_data.size(); i++)
      if (obs_data[i] !== tx_data[i] || obs_strb[i] !== tx_strb[i]) bad++;
    checks++;
    if (obs_data.size() != 4 || bad != 0 || obs_nlast != 1 || !last_final) begin
      errors++; $display("FAIL burst4_beats got n=%0d bad=%0d lasts=%0d exp 4/0/1", obs_data.size(), bad, obs_nlast);
    end
  endtask

  task automatic test_stall();
    int bad = 0;
    fill_data(2);
    run_txn(32'h2000, 8'd2, 3'd2, 0, 0, 1, 5, 2'b00, 0, 0, 0);
    for (int i = 0; i < obs_data.size() && i < tx_data.size(); i++)
      if (obs_data[i] !== tx_data[i]) bad++;
    checks++;
    if (gap_leak || last_stray || obs_data.size() != 3 || bad != 0 || obs_nlast != 1 || !last_final) begin
      errors++; $display("FAIL stall got leak=%0d stray=%0d n=%0d bad=%0d exp 0/0/3/0", gap_leak, last_stray, obs_data.size(), bad);
    end
  endtask

  task automatic test_error();
    for (int t = 0; t < 3; t++) begin
      fill_data(1);
      run_txn(32'h3000 + 32'(t * 16), 8'd1, 3'd2, 0, 0, 0, 0, 2'b10, 2, 0, 0);
      checks++;
      if (obs_resp !== 2'b10 || hang) begin errors++; $display("FAIL error_resp got %b exp 10", obs_resp); end
    end
    checks++;
    if (err_cnt !== 8'd3) begin errors++; $display("FAIL error_count got %0d exp 3", err_cnt); end
  endtask

  task automatic test_b_spurious();
    fill_data(2);
    run_txn(32'h4000, 8'd2, 3'd1, 1, 0, 0, 0, 2'b00, 0, 0, 1);
    checks++;
    if (b_early || t_done <= t_lastw || obs_data.size() != 3 || hang) begin
      errors++; $display("FAIL b_spurious got early=%0d done_at=%0d last_at=%0d exp b_ready only after last", b_early, t_done, t_lastw);
    end
  endtask

  task automatic test_max_len();
    fill_data(255);
    run_txn(32'h5000, 8'hFF, 3'd2, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    checks++;
    if (obs_data.size() != 256 || obs_nlast != 1 || !last_final || obs_data[255] !== tx_data[255] || hang) begin
      errors++; $display("FAIL max_len got n=%0d lasts=%0d exp 256/1", obs_data.size(), obs_nlast);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 25; t++) begin
      int len, bad;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [1:0]  bresp;
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 7);
      addr = $urandom; size = 3'($urandom_range(0, 7)); bresp = 2'($urandom_range(0, 3));
      fill_data(len);
      run_txn(addr, 8'(len), size, $urandom_range(0, 3), 2, $urandom_range(1, 3), $urandom_range(0, 4),
              bresp, $urandom_range(0, 4), 0, 0);
      bad = 0;
      for (int i = 0; i < obs_data.size() && i < tx_data.size(); i++)
        if (obs_data[i] !== tx_data[i] || obs_strb[i] !== tx_strb[i]) bad++;
      checks++;
      if (obs_aw_addr !== addr || obs_aw_len !== 8'(len) || obs_aw_size !== size || aw_unstable || w_early) begin
        errors++; $display("FAIL rand_aw[%0d] got %h/%0d/%0d exp %h/%0d/%0d", t, obs_aw_addr, obs_aw_len, obs_aw_size, addr, len, size);
      end
      checks++;
      if (obs_data.size() != len + 1 || bad != 0 || obs_nlast != 1 || !last_final || last_stray) begin
        errors++; $display("FAIL rand_beats[%0d] got n=%0d bad=%0d lasts=%0d exp %0d/0/1", t, obs_data.size(), bad, obs_nlast, len + 1);
      end
      checks++;
      if (obs_resp !== bresp || int'(err_cnt) != err_exp || hang) begin
        errors++; $display("FAIL rand_resp[%0d] got %b/%0d exp %b/%0d", t, obs_resp, err_cnt, bresp, err_exp);
      end
    end
  endtask

`ifdef AXI_MST_WR_TIMEOUT_EN
  task automatic test_timeout();
    fill_data(1);
    run_txn(32'h6000, 8'd1, 3'd2, 0, 0, 0, 0, 2'b00, 0, 1, 0);
    checks++;
    if (obs_resp !== 2'b10 || !obs_timeout || t_done - t_lastw != 17 || done_after || hang) begin
      errors++; $display("FAIL timeout got resp=%b to=%0d after_resp_entry=%0d exp 10/1/16", obs_resp, obs_timeout, t_done - t_lastw - 1);
    end
    checks++;
    if (int'(err_cnt) != err_exp) begin errors++; $display("FAIL timeout_errcnt got %0d exp %0d", err_cnt, err_exp); end
    fill_data(0);
    run_txn(32'h6100, 8'd0, 3'd2, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    checks++;
    if (done_n != 1 || obs_resp !== 2'b00 || obs_timeout) begin
      errors++; $display("FAIL timeout_next got done=%0d resp=%b exp 1/00", done_n, obs_resp);
    end
  endtask
`endif

  task automatic test_saturate();
    while (err_exp < 255) begin
      fill_data(0);
      run_txn(32'h7000, 8'd0, 3'd2, 0, 0, 0, 0, 2'b11, 0, 0, 0);
    end
    checks++;
    if (err_cnt !== 8'hFF) begin errors++; $display("FAIL sat_reach got %0d exp 255", err_cnt); end
    fill_data(0);
    run_txn(32'h7000, 8'd0, 3'd2, 0, 0, 0, 0, 2'b10, 0, 0, 0);
    checks++;
    if (err_cnt !== 8'hFF || obs_resp !== 2'b10) begin
      errors++; $display("FAIL sat_hold got %0d/%b exp 255/10", err_cnt, obs_resp);
    end
  endtask

  task automatic test_reset_mid();
    bit cmd_done = 1'b0;
    int nb = 0;
    fill_data(7);
    for (int k = 0; k < 50 && nb < 2; k++) begin
      @(negedge aclk);
      cmd_valid = !cmd_done; cmd_addr = 32'h8000; cmd_len = 8'd7; cmd_size = 3'd2;
      wd_valid = cmd_done; wd_data = tx_data[nb]; wd_strb = tx_strb[nb];
      axi.aw_ready = 1'b1; axi.w_ready = 1'b1; axi.b_valid = 1'b0;
      #1;
      if (cmd_valid && cmd_ready) cmd_done = 1'b1;
      if (axi.w_valid && axi.w_ready) nb++;
    end
    @(negedge aclk);
    wd_data = tx_data[nb];
    #1;
    checks++;
    if (axi.w_valid !== 1'b1 || nb != 2) begin errors++; $display("FAIL rst_mid_setup got w_valid=%b beats=%0d exp 1/2", axi.w_valid, nb); end
    areset_n = 1'b0;
    #1;
    checks++;
    if ({axi.aw_valid, axi.w_valid, axi.b_ready} !== 3'b000 || err_cnt !== 8'd0) begin
      errors++; $display("FAIL rst_mid_async got %b err=%0d exp 000/0", {axi.aw_valid, axi.w_valid, axi.b_ready}, err_cnt);
    end
    @(negedge aclk);
    idle_inputs();
    areset_n = 1'b1;
    err_exp = 0;
    @(negedge aclk); #1;
    checks++;
    if (cmd_ready !== 1'b1 || err_cnt !== 8'd0) begin
      errors++; $display("FAIL rst_mid_release got ready=%b err=%0d exp 1/0", cmd_ready, err_cnt);
    end
  endtask

  initial begin
    areset_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_burst4();
    test_stall();
    test_error();
    test_b_spurious();
    test_max_len();
    test_random();
`ifdef AXI_MST_WR_TIMEOUT_EN
    test_timeout();
`endif
    test_saturate();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
